// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer for the 8-bit A/B accumulator CPU: owns the PC, fetches
// 15-bit instructions over a req/ready handshake and issues the register write strobe.
module instr_sequencer #(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            halt_req,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [14:0]     imem_rdata,
  output logic [6:0]      opcode,
  output logic [7:0]      k8,
  output logic            wr_en,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [15:0]     instr_count
);
  localparam logic [PC_W-1:0] PC_LAST       = PC_W'(PROG_LEN - 1);
  localparam logic [PC_W-1:0] PC_ONE        = PC_W'(1);
  localparam logic [6:0]      OP_LAST_LEGAL = 7'h24;
  localparam logic [6:0]      OP_HALT       = 7'h7F;

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_t;

  state_t          state, state_nx;
  logic [14:0]     ir;
  logic            step_mode;
  logic            halt_pend;
  logic            op_legal;
  logic            op_halt;
  logic [PC_W-1:0] pc_next;

  assign opcode    = ir[14:8];
  assign k8        = ir[7:0];
  assign op_legal  = (opcode <= OP_LAST_LEGAL);
  assign op_halt   = (opcode == OP_HALT);
  assign pc_next   = (pc == PC_LAST) ? '0 : pc + PC_ONE;
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign busy      = (state != IDLE);
  assign halted    = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start || step) state_nx = FETCH;
      FETCH:   if (imem_ready) state_nx = DECODE;
      DECODE:  state_nx = EXEC;
      EXEC:    state_nx = (step_mode || halt_pend || halt_req || op_halt) ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  // The write strobe is registered off DECODE so it lines up exactly with EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      ir          <= '0;
      wr_en       <= 1'b0;
      step_mode   <= 1'b0;
      halt_pend   <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      wr_en <= (state == DECODE) && op_legal;

      if (state_nx == IDLE)      halt_pend <= 1'b0;
      else if (busy && halt_req) halt_pend <= 1'b1;

      if (wr_en && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;

      case (state)
        IDLE: begin
          if (start) begin
            pc        <= '0;
            illegal   <= 1'b0;
            step_mode <= 1'b0;
          end else if (step) begin
            step_mode <= 1'b1;
          end
        end
        FETCH: if (imem_ready) ir <= imem_rdata;
        EXEC: begin
          if (!op_halt) begin
            pc <= pc_next;
            if (!op_legal) illegal <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized programs
// compared against an instruction-level reference model with a tiny A/B datapath.
module tb_instr_sequencer;
  localparam int PLEN = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, step = 1'b0, halt_req = 1'b0;
  logic        imem_req, imem_ready, wr_en, busy, halted, illegal;
  logic [7:0]  imem_addr, pc, k8;
  logic [14:0] imem_rdata;
  logic [6:0]  opcode;
  logic [15:0] instr_count;

  logic        start2 = 1'b0, step2 = 1'b0, halt2 = 1'b0;
  logic        imem_req2, wr2, busy2, halted2, illegal2;
  logic [7:0]  addr2, pc2, k82;
  logic [6:0]  opcode2;
  logic [15:0] count2;

  logic [14:0] mem [0:PLEN-1];
  int          wait_n = 0;
  int          wcnt;
  logic [7:0]  dp_a, dp_b;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  int          m_pc, m_count, m_illegal;
  logic [7:0]  m_a, m_b;
  logic [14:0] m_ir;
  int          exp_wr[$], exp_fpc[$], obs_wr[$], obs_fpc[$];

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(8), .PROG_LEN(PLEN)) u_dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .opcode(opcode), .k8(k8), .wr_en(wr_en), .pc(pc),
    .busy(busy), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  instr_sequencer #(.PC_W(8), .PROG_LEN(4)) u_wrap (
    .clk(clk), .rst(rst), .start(start2), .step(step2), .halt_req(halt2),
    .imem_req(imem_req2), .imem_addr(addr2), .imem_ready(imem_req2),
    .imem_rdata(15'h0101), .opcode(opcode2), .k8(k82), .wr_en(wr2), .pc(pc2),
    .busy(busy2), .halted(halted2), .illegal(illegal2), .instr_count(count2)
  );

  // Instruction memory that answers after wait_n pending cycles.
  assign imem_rdata = mem[imem_addr];
  assign imem_ready = imem_req && (wcnt >= wait_n);

  always @(posedge clk or posedge rst) begin
    if (rst)                          wcnt <= 0;
    else if (!imem_req || imem_ready) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end

  // Register file the control unit would drive: MOV A,k / ADD A,k / INC B.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a <= 8'h00;
      dp_b <= 8'h00;
    end else if (wr_en) begin
      case (opcode)
        7'h02:   dp_a <= k8;
        7'h06:   dp_a <= dp_a + k8;
        7'h24:   dp_b <= dp_b + 8'd1;
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pc = 0; m_count = 0; m_illegal = 0; m_a = 8'h00; m_b = 8'h00; m_ir = 15'h0;
  endtask

  task automatic fillHalt();
    for (int i = 0; i < PLEN; i++) mem[i] = 15'h7F00;
  endtask

  // Instruction-level model: each instruction costs 3 cycles plus fetch waits.
  task automatic modelRun(input bit do_start, input int waits, input int halt_instr,
                          output int hc, output int end_c);
    int  t, n;
    bit  done, one_shot;
    logic [6:0] op;
    logic [7:0] k;
    t = 0; n = 0; done = 0; hc = -1;
    one_shot = !do_start;
    if (do_start) begin
      m_pc = 0;
      m_illegal = 0;
    end
    exp_wr.delete();
    exp_fpc.delete();
    while (!done && n < 1000) begin
      exp_fpc.push_back(m_pc);
      if (n == halt_instr) hc = t + 1;
      m_ir = mem[m_pc];
      op = m_ir[14:8];
      k  = m_ir[7:0];
      t += 3 + waits;
      if (op == 7'h7F) begin
        done = 1;
      end else begin
        if (op <= 7'h24) begin
          exp_wr.push_back(t);
          if (m_count < 65535) m_count++;
          if (op == 7'h02) m_a = k;
          if (op == 7'h06) m_a = 8'(m_a + k);
          if (op == 7'h24) m_b = 8'(m_b + 1);
        end else begin
          m_illegal = 1;
        end
        m_pc = (m_pc + 1) % PLEN;
        if (one_shot || n == halt_instr) done = 1;
      end
      n++;
    end
    end_c = t + 1;
  endtask

  // Called on a falling edge with the DUT idle; returns on the falling edge where halted is seen.
  task automatic applyStimulus(input bit do_start, input bit do_step, input int waits,
                               input int halt_instr);
    int hc, end_c, got_end, ill_first;
    bit prev_req;
    logic [7:0] prev_addr;
    ill_first = do_start ? 0 : m_illegal;
    wait_n = waits;
    modelRun(do_start, waits, halt_instr, hc, end_c);
    obs_wr.delete();
    obs_fpc.delete();
    got_end = -1;
    prev_req = 0;
    prev_addr = '0;
    start = do_start;
    step  = do_step;
    for (int c = 1; c <= end_c + 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        step  = 1'b0;
        checkOutput("busy_after_go", busy, 1);
        checkOutput("illegal_after_go", illegal, ill_first);
      end
      halt_req = (c == hc);
      if (wr_en) obs_wr.push_back(c);
      if (imem_req) begin
        if (!prev_req) obs_fpc.push_back(imem_addr);
        else checkOutput("addr_stable", imem_addr, prev_addr);
      end
      prev_req  = imem_req;
      prev_addr = imem_addr;
      if (halted) begin
        got_end = c;
        break;
      end
    end
    halt_req = 1'b0;
    checkOutput("halt_cycle", got_end, end_c);
    checkOutput("wr_pulses", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
      checkOutput("wr_cycle", obs_wr[i], exp_wr[i]);
    checkOutput("fetches", obs_fpc.size(), exp_fpc.size());
    for (int i = 0; i < obs_fpc.size() && i < exp_fpc.size(); i++)
      checkOutput("fetch_pc", obs_fpc[i], exp_fpc[i]);
    checkOutput("pc", pc, m_pc);
    checkOutput("instr_count", instr_count, m_count);
    checkOutput("illegal", illegal, m_illegal);
    checkOutput("opcode_hold", opcode, m_ir[14:8]);
    checkOutput("k8_hold", k8, m_ir[7:0]);
    checkOutput("reg_a", dp_a, m_a);
    checkOutput("reg_b", dp_b, m_b);
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_imem_req"}, imem_req, 0);
    checkOutput({pfx, "_wr_en"}, wr_en, 0);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_halted"}, halted, 1);
    checkOutput({pfx, "_pc"}, pc, 0);
    checkOutput({pfx, "_opcode"}, opcode, 0);
    checkOutput({pfx, "_k8"}, k8, 0);
    checkOutput({pfx, "_illegal"}, illegal, 0);
    checkOutput({pfx, "_count"}, instr_count, 0);
  endtask

  initial begin
    int fetches, len, w, hi;
    bit prev2, reached;
    logic [6:0] op;

    // Reset state
    fillHalt();
    modelReset();
    #3;
    checkResetOutputs("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Three-instruction program, zero wait states
    mem[0] = 15'h0205; mem[1] = 15'h0603; mem[2] = 15'h7F00;
    applyStimulus(1, 0, 0, -1);
    checkOutput("s1_a_is_8", dp_a, 8'd8);
    checkOutput("s1_pc_is_2", pc, 2);
    checkOutput("s1_count_is_2", instr_count, 2);

    // Same program with four wait states on every fetch
    applyStimulus(1, 0, 4, -1);
    checkOutput("s2_a_is_8", dp_a, 8'd8);
    checkOutput("s2_pc_is_2", pc, 2);

    // Park at pc 1 via halt_req, then single-step twice
    mem[2] = 15'h2400; mem[3] = 15'h7F00;
    applyStimulus(1, 0, 0, 0);
    checkOutput("step_pre_pc", pc, 1);
    applyStimulus(0, 1, 0, -1);
    checkOutput("step1_pc", pc, 2);
    applyStimulus(0, 1, 0, -1);
    checkOutput("step2_pc", pc, 3);

    // halt_req during instruction 1 fetch of a 10-instruction program
    fillHalt();
    for (int i = 0; i < 10; i++) mem[i] = 15'h0601;
    applyStimulus(1, 0, 0, 1);
    checkOutput("halt_pc_is_2", pc, 2);
    applyStimulus(1, 1, 0, -1);
    checkOutput("start_wins_pc", pc, 10);

    // Illegal opcode followed by INC B; sticky until next start
    fillHalt();
    mem[0] = 15'h5000; mem[1] = 15'h2400;
    applyStimulus(1, 0, 1, -1);
    checkOutput("ill_set", illegal, 1);
    applyStimulus(0, 1, 0, -1);
    checkOutput("ill_sticky", illegal, 1);
    mem[0] = 15'h0201;
    applyStimulus(1, 0, 0, -1);
    checkOutput("ill_cleared", illegal, 0);

    // Randomized programs, wait states, modes and halt requests
    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(1, 14);
      for (int i = 0; i < PLEN; i++) begin
        case ($urandom_range(0, 5))
          0:       op = 7'h02;
          1:       op = 7'h06;
          2:       op = 7'h24;
          3:       op = 7'($urandom_range(0, 36));
          4:       op = 7'($urandom_range(37, 126));
          default: op = ($urandom_range(0, 3) == 0) ? 7'h7F : 7'h06;
        endcase
        mem[i] = {op, 8'($urandom_range(0, 255))};
      end
      mem[len] = 15'h7F00;
      w  = $urandom_range(0, 3);
      hi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      if ($urandom_range(0, 3) != 0) applyStimulus(1, 0, w, hi);
      else                           applyStimulus(0, 1, w, hi);
    end

    // PROG_LEN=4 wrap, then reset in the middle of DECODE
    fetches = 0;
    prev2 = 0;
    reached = 0;
    start2 = 1'b1;
    for (int c = 1; c <= 60 && !reached; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (imem_req2 && !prev2) begin
        fetches++;
        if (fetches <= 6) checkOutput("wrap_pc", addr2, (fetches - 1) % 4);
        if (fetches == 7) begin
          checkOutput("wrap_count", count2, 6);
          @(negedge clk);
          checkOutput("decode_busy", busy2, 1);
          checkOutput("decode_req", imem_req2, 0);
          #1 rst = 1'b1;
          #1;
          checkOutput("mid_rst_req", imem_req2, 0);
          checkOutput("mid_rst_busy", busy2, 0);
          checkOutput("mid_rst_halted", halted2, 1);
          checkOutput("mid_rst_wr", wr2, 0);
          checkOutput("mid_rst_pc", pc2, 0);
          checkOutput("mid_rst_opcode", opcode2, 0);
          checkOutput("mid_rst_k8", k82, 0);
          checkOutput("mid_rst_count", count2, 0);
          checkOutput("mid_rst_illegal", illegal2, 0);
          checkResetOutputs("mid_rst_main");
          reached = 1;
        end
      end
      prev2 = imem_req2;
    end
    checkOutput("wrap_fetches", fetches, 7);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
